jtag_scan_master: RTL and testbench
===================================

// Module: jtag_scan_master
// PURPOSE
//   Host-side JTAG driver: the initiator end of the DMI JTAG TAP link. It turns single
//   scan commands into TCK/TMS/TDI waveforms and samples TDO. Commands are IR scan,
//   DR scan or TAP reset; each returns one response with the shifted-out bits.
//   Sits in the debug-transport test harness and in the SoC-level JTAG bridge,
//   clocked from the system clock.
// PARAMETERS
//   MaxLen  41  maximum scan length in bits (DMI: abits 7 + data 32 + op 2)
//   ClkDiv  4   TCK half-period in clk_i cycles; legal range >= 1
//   LenW    $clog2(MaxLen+1)  localparam, width of the length field
// PORTS
//   clk_i        in   1       system clock
//   rst_ni       in   1       asynchronous reset, active low
//   req_valid_i  in   1       command valid
//   req_ready_o  out  1       command accepted when valid & ready
//   req_op_i     in   2       0 DR scan; 1 IR scan; 2 TAP reset; 3 no-op
//   req_len_i    in   LenW    number of shift bits
//   req_data_i   in   MaxLen  TDI data, LSB shifted first
//   rsp_valid_o  out  1       response valid, held until rsp_ready_i
//   rsp_ready_i  in   1       response consumed
//   rsp_data_o   out  MaxLen  captured TDO bits, bit i = i-th shifted bit
//   busy_o       out  1       a command is in progress (not IDLE)
//   tck_o        out  1       JTAG clock
//   tms_o        out  1       JTAG mode select
//   tdi_o        out  1       JTAG data toward the TAP
//   tdo_i        in   1       JTAG data from the TAP
// BEHAVIOUR
//   Reset values: tck_o 0, tms_o 1, tdi_o 0, rsp_valid_o 0, rsp_data_o 0, busy_o 0, FSM in IDLE.
//   - req_ready_o = (state==IDLE) & ~rsp_valid_o, so it is 1 straight after reset.
//   TAP position: the master regards the TAP as parked in Run-Test/Idle between commands.
//   - After power-up the first command must be op 2. This is not enforced.
//   TCK: idle low. Each TCK step = ClkDiv cycles low, then ClkDiv cycles high.
//   - tms_o/tdi_o update only on the clk edge that starts the low phase.
//   - tdo_i is registered on the clk edge where tck_o goes 0->1.
//   Length: req_len_i==0 is treated as 1. req_len_i>MaxLen is clamped to MaxLen.
//   - Call the result N.
//   FSM: IDLE -> HDR -> SHIFT -> TRL -> RESP -> IDLE. op 2 uses IDLE -> RST -> RESP.
//   op 3 goes IDLE -> RESP with rsp_data_o=0 and no TCK activity.
//   - HDR  DR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
//          IR: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
//   - SHIFT: N steps. tdi_o = data[i]. TMS=0 for steps 0..N-2; TMS=1 on step N-1 (Exit1).
//   - TRL: TMS 1 (Update), then 0 (Run-Test/Idle).
//   - RST: TMS 1,1,1,1,1, then 0 (Test-Logic-Reset, then Run-Test/Idle).
//   - tdi_o=0 in every step outside SHIFT.
//   - tms_o stays at its last driven value (0) in IDLE.
//   - TCK steps per command: DR N+5, IR N+6, RST 6.
//   Response:
//   - rsp_data_o bit i = tdo_i sampled at SHIFT step i; bits >= N are 0.
//   - rsp_valid_o rises on the clk cycle after the high phase of the last step ends.
//     tck_o is back at 0 by then.
//   - rsp_valid_o and rsp_data_o hold stable until rsp_valid_o & rsp_ready_i.
//     The FSM then returns to IDLE on the next cycle.
//   Simultaneous events: a new request is not accepted on the rsp handshake cycle;
//   the earliest acceptance is the following cycle.
//   - req_* inputs are captured at acceptance; later changes are ignored.
//   Reset mid-operation: rst_ni low forces all reset values asynchronously.
//   - The command in flight is dropped and no response is produced.
//   - TAP state is then unknown; the caller must issue op 2.
// TESTING
//   1. op 2 -> 6 TCK rises seeing TMS 1,1,1,1,1,0, then rsp_valid_o with rsp_data_o=0.
//   2. Against a 5-bit-IR TAP model: IR scan, len 5, data 5'h11.
//      -> TMS 1,1,0,0,0,0,0,0,1,1,0; TDI shift 1,0,0,0,1; rsp_data_o=5'h05 (IR capture pattern).
//   3. Then DR scan, len 32, data 0, with IR=IDCODE and IdcodeValue 32'h00000001
//      -> 37 TCK rises; rsp_data_o=32'h00000001.
//   4. Hold rsp_ready_i=0 for 20 cycles with req_valid_i=1.
//      -> rsp_valid_o and rsp_data_o stay stable; req_ready_o=0; accept on the cycle after the handshake.
//   5. ClkDiv=1 and ClkDiv=3 builds -> TCK period 2/6 clk.
//      -> tms_o/tdi_o stable >= ClkDiv cycles before each rise; len 0 gives 1 shift bit; len 50 clamps to 41.
//   6. rst_ni low during SHIFT of a DR scan.
//      -> tck_o=0, tms_o=1, tdi_o=0, rsp_valid_o=0 immediately; req_ready_o=1 after release; no response produced.

Source files
------------

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG driver turning IR/DR/reset commands into TCK/TMS/TDI waveforms and capturing TDO.
module jtag_scan_master #(
  parameter int MaxLen = 41,
  parameter int ClkDiv = 4,
  localparam int LenW = $clog2(MaxLen + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [LenW-1:0]   req_len_i,
  input  logic [MaxLen-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);
  localparam int DivW = $clog2(2 * ClkDiv);
  typedef enum logic [2:0] {IDLE, HDR, SHIFT, TRL, RST, RESP} state_t;
  state_t            r_state;
  logic [DivW-1:0]   r_div;
  logic [LenW-1:0]   r_cnt, r_n;
  logic              r_ir, r_tck, r_tms, r_tdi, r_valid;
  logic [MaxLen-1:0] r_sh, r_rsp;
  logic              w_rise, w_end;
  logic [LenW-1:0]   w_n;
  assign w_rise = r_div == DivW'(ClkDiv - 1);
  assign w_end  = r_div == DivW'(2 * ClkDiv - 1);
  assign w_n = req_len_i == '0 ? LenW'(1) : (req_len_i > LenW'(MaxLen) ? LenW'(MaxLen) : req_len_i);
  assign req_ready_o = (r_state == IDLE) & ~r_valid;
  assign rsp_valid_o = r_valid;
  assign rsp_data_o  = r_rsp;
  assign busy_o      = r_state != IDLE;
  assign tck_o       = r_tck;
  assign tms_o       = r_tms;
  assign tdi_o       = r_tdi;
  // Each step: r_div 0..ClkDiv-1 is the low phase, the rest high; step changes land on the falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_ir    <= 1'b0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_valid <= 1'b0;
      r_sh    <= '0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid_i && !r_valid) begin
          r_div <= '0;
          r_cnt <= '0;
          r_n   <= w_n;
          r_ir  <= req_op_i == 2'd1;
          r_sh  <= req_data_i;
          r_rsp <= '0;
          r_tdi <= 1'b0;
          case (req_op_i)
            2'd0, 2'd1: begin r_state <= HDR; r_tms <= 1'b1; end
            2'd2:       begin r_state <= RST; r_tms <= 1'b1; end
            default:    begin r_state <= RESP; r_valid <= 1'b1; end
          endcase
        end
        RESP: if (rsp_ready_i) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_div <= w_end ? '0 : r_div + 1'b1;
          if (w_rise) begin
            r_tck <= 1'b1;
            if (r_state == SHIFT) r_rsp[r_cnt] <= tdo_i;
          end
          if (w_end) begin
            r_tck <= 1'b0;
            r_tdi <= 1'b0;
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
              HDR: if (r_cnt == (r_ir ? LenW'(3) : LenW'(2))) begin
                r_state <= SHIFT;
                r_cnt   <= '0;
                r_tms   <= r_n == LenW'(1);
                r_tdi   <= r_sh[0];
                r_sh    <= r_sh >> 1;
              end else r_tms <= r_ir && r_cnt == '0;
              SHIFT: if (r_cnt == r_n - 1'b1) begin
                r_state <= TRL;
                r_cnt   <= '0;
                r_tms   <= 1'b1;
              end else begin
                r_tms <= r_cnt + 1'b1 == r_n - 1'b1;
                r_tdi <= r_sh[0];
                r_sh  <= r_sh >> 1;
              end
              TRL: if (r_cnt == LenW'(1)) begin
                r_state <= RESP;
                r_valid <= 1'b1;
              end else r_tms <= 1'b0;
              RST: if (r_cnt == LenW'(5)) begin
                r_state <= RESP;
                r_valid <= 1'b1;
              end else r_tms <= r_cnt < LenW'(4);
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed bench with a 5-bit-IR TAP model on the ClkDiv=4 master and TDI->TDO loopback on a ClkDiv=1 master.
module tb_jtag_scan_master;
  localparam int ML = 41, LW = 6;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, rsp_ready = 0, sel = 0;
  logic [1:0] req_op = 0;
  logic [LW-1:0] req_len = 0;
  logic [ML-1:0] req_data = 0;
  logic rdy0, rdy1, v0, v1, b0, b1, tck0, tck1, tms0, tms1, tdi0, tdi1, tdo0 = 0;
  logic [ML-1:0] d0, d1;
  logic rdy, rv;
  logic [ML-1:0] rd;
  assign rdy = sel ? rdy1 : rdy0;
  assign rv  = sel ? v1 : v0;
  assign rd  = sel ? d1 : d0;
  jtag_scan_master u0 (.clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy0),
    .req_op_i(req_op), .req_len_i(req_len), .req_data_i(req_data), .rsp_valid_o(v0),
    .rsp_ready_i(rsp_ready & ~sel), .rsp_data_o(d0), .busy_o(b0), .tck_o(tck0), .tms_o(tms0),
    .tdi_o(tdi0), .tdo_i(tdo0));
  jtag_scan_master #(.ClkDiv(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & sel), .req_ready_o(rdy1),
    .req_op_i(req_op), .req_len_i(req_len), .req_data_i(req_data), .rsp_valid_o(v1),
    .rsp_ready_i(rsp_ready & sel), .rsp_data_o(d1), .busy_o(b1), .tck_o(tck1), .tms_o(tms1),
    .tdi_o(tdi1), .tdo_i(tdi1));

  typedef enum {TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR, SIS, CIR, SIR, E1I, PIR, E2I, UIR} tap_t;
  tap_t ts = TLR;
  logic [4:0] ir = 5'h11, irs = 0;
  logic [31:0] drs = 0;
  function automatic tap_t nxt(tap_t s, logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDS : RTI;
      SDS: return m ? SIS : CDR;
      CDR: return m ? E1D : SDR;
      SDR: return m ? E1D : SDR;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SDR;
      UDR: return m ? SDS : RTI;
      SIS: return m ? TLR : CIR;
      CIR: return m ? E1I : SIR;
      SIR: return m ? E1I : SIR;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction
  // IR 5'h11 selects a 32-bit IDCODE of 1; anything else is a 1-bit bypass.
  always @(posedge tck0) begin
    case (ts)
      TLR: ir <= 5'h11;
      CIR: irs <= 5'h05;
      SIR: irs <= {tdi0, irs[4:1]};
      UIR: ir <= irs;
      CDR: drs <= (ir == 5'h11) ? 32'h1 : 32'h0;
      SDR: drs <= (ir == 5'h11) ? {tdi0, drs[31:1]} : {31'h0, tdi0};
      default: ;
    endcase
    ts <= nxt(ts, tms0);
  end
  always @(negedge tck0) tdo0 <= (ts == SIR) ? irs[0] : (ts == SDR) ? drs[0] : 1'b0;

  int nr = 0, nr1 = 0, stab = 0, minst = 99;
  logic [63:0] ltms = 0, ltdi = 0;
  logic [1:0] ptd = 0;
  time tl0 = 0, per0 = 0, tl1 = 0, per1 = 0;
  always @(posedge tck0) begin
    if (nr < 64) begin ltms[nr] = tms0; ltdi[nr] = tdi0; end
    nr++;
    per0 = $time - tl0;
    tl0 = $time;
    if (stab < minst) minst = stab;
  end
  always @(posedge tck1) begin
    nr1++;
    per1 = $time - tl1;
    tl1 = $time;
  end
  always @(negedge clk) begin
    if ({tms0, tdi0} !== ptd) stab = 0; else stab++;
    ptd = {tms0, tdi0};
  end

  int pass = 0, total = 0;
  logic [ML-1:0] r;

  task automatic clear();
    nr = 0; nr1 = 0; ltms = 0; ltdi = 0; minst = 99;
  endtask
  task automatic send(input logic s, input logic [1:0] op, input logic [LW-1:0] len, input logic [ML-1:0] d);
    int t = 0;
    @(negedge clk);
    sel = s; req_op = op; req_len = len; req_data = d; req_valid = 1;
    while (!rdy && t < 200) begin @(negedge clk); t++; end
    total++;
    if (!rdy) $display("FAIL accept: req_ready=%b required 1", rdy); else pass++;
    @(posedge clk);
    #1 req_valid = 0; req_data = '0; req_op = 2'd3; req_len = '0;
  endtask
  task automatic get(output logic [ML-1:0] d);
    int t = 0;
    @(negedge clk);
    while (!rv && t < 3000) begin @(negedge clk); t++; end
    total++;
    if (!rv) $display("FAIL rsp_timeout: rsp_valid=%b required 1", rv); else pass++;
    d = rd;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    #23;
    total++; if ({tck0, tms0, tdi0, v0, b0, rdy0} !== 6'b010001) $display("FAIL reset_outs: %b required 010001", {tck0, tms0, tdi0, v0, b0, rdy0}); else pass++;
    total++; if (d0 !== '0) $display("FAIL reset_data: %h required 0", d0); else pass++;
    @(negedge clk) rst_n = 1;
  endtask
  task automatic test_tap_reset();
    clear(); send(0, 2'd2, 0, 0); get(r);
    total++; if (nr !== 6) $display("FAIL rst_rises: %0d required 6", nr); else pass++;
    total++; if (ltms[5:0] !== 6'b011111) $display("FAIL rst_tms: %b required 011111", ltms[5:0]); else pass++;
    total++; if (r !== '0) $display("FAIL rst_data: %h required 0", r); else pass++;
    total++; if (tms0 !== 1'b0) $display("FAIL idle_tms: %b required 0", tms0); else pass++;
  endtask
  task automatic test_ir();
    clear(); send(0, 2'd1, 5, 41'h11); get(r);
    total++; if (nr !== 11) $display("FAIL ir_rises: %0d required 11", nr); else pass++;
    total++; if (ltms[10:0] !== 11'h303) $display("FAIL ir_tms: %h required 303", ltms[10:0]); else pass++;
    total++; if (ltdi[10:0] !== 11'h110) $display("FAIL ir_tdi: %h required 110", ltdi[10:0]); else pass++;
    total++; if (r !== 41'h05) $display("FAIL ir_data: %h required 05", r); else pass++;
    total++; if (minst < 3) $display("FAIL ir_setup: %0d required >=3", minst); else pass++;
    total++; if (per0 !== 80) $display("FAIL tck_period4: %0t required 80", per0); else pass++;
  endtask
  task automatic test_dr_idcode();
    clear(); send(0, 2'd0, 32, 0); get(r);
    total++; if (nr !== 37) $display("FAIL dr_rises: %0d required 37", nr); else pass++;
    total++; if (ltms[36:0] !== 37'h0C_0000_0001) $display("FAIL dr_tms: %h required 0c00000001", ltms[36:0]); else pass++;
    total++; if (r !== 41'h1) $display("FAIL dr_idcode: %h required 1", r); else pass++;
  endtask
  task automatic test_back_to_back();
    logic [ML-1:0] hd;
    int t = 0, bad = 0;
    clear(); send(0, 2'd0, 32, 41'hA5A5A5A5);
    while (!v0 && t < 3000) begin @(negedge clk); t++; end
    hd = d0;
    req_op = 2'd3; req_len = 0; req_data = 0; req_valid = 1;
    repeat (20) begin @(negedge clk); if (!v0 || d0 !== hd || rdy0) bad++; end
    total++; if (bad != 0 || hd !== 41'h1) $display("FAIL hold: bad=%0d data=%h required 0/1", bad, hd); else pass++;
    rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
    total++; if ({b0, v0, rdy0} !== 3'b001) $display("FAIL after_hs: busy,valid,ready=%b required 001", {b0, v0, rdy0}); else pass++;
    @(negedge clk);
    total++; if ({b0, v0} !== 2'b11 || d0 !== '0) $display("FAIL nop_accept: busy,valid=%b data=%h required 11/0", {b0, v0}, d0); else pass++;
    total++; if (nr !== 37) $display("FAIL nop_tck: %0d rises required 37", nr); else pass++;
    req_valid = 0; rsp_ready = 1;
    @(negedge clk) rsp_ready = 0;
  endtask
  task automatic test_fast();
    clear(); send(1, 2'd0, 0, 41'h3); get(r);
    total++; if (r !== 41'h1) $display("FAIL len0_data: %h required 1", r); else pass++;
    total++; if (nr1 !== 6) $display("FAIL len0_rises: %0d required 6", nr1); else pass++;
    total++; if (per1 !== 20) $display("FAIL tck_period1: %0t required 20", per1); else pass++;
    clear(); send(1, 2'd0, 50, 41'h1FF_FFFF_FFFF); get(r);
    total++; if (r !== 41'h1FF_FFFF_FFFF) $display("FAIL clamp_data: %h required 1ffffffffff", r); else pass++;
    total++; if (nr1 !== 46) $display("FAIL clamp_rises: %0d required 46", nr1); else pass++;
    sel = 0;
  endtask
  task automatic test_reset_mid();
    int t = 0, seen = 0;
    clear(); send(0, 2'd0, 32, 0);
    while (nr < 10 && t < 3000) begin @(negedge clk); t++; end
    rst_n = 0;
    #1;
    total++; if ({tck0, tms0, tdi0, v0, b0} !== 5'b01000) $display("FAIL mid_reset: %b required 01000", {tck0, tms0, tdi0, v0, b0}); else pass++;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    total++; if (rdy0 !== 1'b1) $display("FAIL mid_ready: %b required 1", rdy0); else pass++;
    repeat (400) begin @(negedge clk); if (v0) seen++; end
    total++; if (seen != 0) $display("FAIL mid_no_rsp: %0d valid cycles required 0", seen); else pass++;
    clear(); send(0, 2'd2, 0, 0); get(r);
    total++; if (nr !== 6) $display("FAIL recover_rst: %0d required 6", nr); else pass++;
    send(0, 2'd0, 32, 0); get(r);
    total++; if (r !== 41'h1) $display("FAIL recover_dr: %h required 1", r); else pass++;
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_ir();
    test_dr_idcode();
    test_back_to_back();
    test_fast();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
